// File: rtl/mandelbrot_frame_scheduler.sv
// Walks a frame in raster order, hands each pixel to one mandelbrot engine and
// streams the results into a framebuffer write port. A watchdog recovers from a silent engine.
module mandelbrot_frame_scheduler #(
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int ADDR_WIDTH  = 19,
    parameter int WDOG_CYCLES = 1023
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [15:0]           cfg_center_x,
    input  logic [15:0]           cfg_center_y,
    input  logic [7:0]            cfg_zoom,
    input  logic [5:0]            cfg_max_iter,
    output logic [9:0]            eng_pixel_x,
    output logic [9:0]            eng_pixel_y,
    output logic                  eng_pixel_valid,
    output logic [15:0]           eng_center_x,
    output logic [15:0]           eng_center_y,
    output logic [7:0]            eng_zoom,
    output logic [5:0]            eng_max_iter,
    output logic                  eng_enable,
    input  logic [5:0]            eng_iteration_count,
    input  logic                  eng_result_valid,
    input  logic                  eng_busy,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [5:0]            wr_data,
    output logic                  wr_in_set,
    output logic                  busy,
    output logic                  frame_done,
    output logic [7:0]            wdog_count
);

    localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);
    localparam logic [9:0] X_LAST = 10'(H_RES - 1);
    localparam logic [9:0] Y_LAST = 10'(V_RES - 1);
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        WRITE,
        ADVANCE
    } state_t;

    state_t                  state_reg, state_next;
    logic [9:0]              x_reg, y_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [WDOG_W-1:0]       wdog_reg;
    logic [7:0]              wdog_count_reg;
    logic [5:0]              data_reg;
    logic                    in_set_reg;
    logic                    frame_done_reg;
    logic [15:0]             center_x_reg, center_y_reg;
    logic [7:0]              zoom_reg;
    logic [5:0]              max_iter_reg;

    logic                    last_pixel;
    logic                    wdog_expired;
    logic                    begin_frame;

    always_comb begin
        state_next   = state_reg;
        last_pixel   = (x_reg == X_LAST) && (y_reg == Y_LAST);
        wdog_expired = (wdog_reg == WDOG_LAST);
        begin_frame  = (state_reg == IDLE) && start && !abort;
        case (state_reg)
            IDLE:    if (begin_frame) state_next = ISSUE;
            ISSUE:   if (!eng_busy && !eng_result_valid) state_next = WAIT;
            WAIT:    if (eng_result_valid || wdog_expired) state_next = WRITE;
            WRITE:   if (wr_ready) state_next = ADVANCE;
            ADVANCE: state_next = last_pixel ? IDLE : ISSUE;
            default: state_next = IDLE;
        endcase
        // Abort outranks every transition once a frame is running.
        if (state_reg != IDLE && abort) state_next = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            x_reg          <= '0;
            y_reg          <= '0;
            addr_reg       <= '0;
            wdog_reg       <= '0;
            wdog_count_reg <= '0;
            data_reg       <= '0;
            in_set_reg     <= 1'b0;
            frame_done_reg <= 1'b0;
            center_x_reg   <= '0;
            center_y_reg   <= '0;
            zoom_reg       <= '0;
            max_iter_reg   <= '0;
        end else begin
            state_reg      <= state_next;
            frame_done_reg <= (state_reg == ADVANCE) && last_pixel && !abort;
            case (state_reg)
                IDLE: begin
                    if (begin_frame) begin
                        center_x_reg   <= cfg_center_x;
                        center_y_reg   <= cfg_center_y;
                        zoom_reg       <= cfg_zoom;
                        max_iter_reg   <= cfg_max_iter;
                        x_reg          <= '0;
                        y_reg          <= '0;
                        addr_reg       <= '0;
                        wdog_count_reg <= '0;
                    end
                end
                ISSUE: wdog_reg <= '0;
                WAIT: begin
                    if (!abort) begin
                        if (eng_result_valid) begin
                            data_reg   <= eng_iteration_count;
                            in_set_reg <= (eng_iteration_count >= max_iter_reg);
                        end else if (wdog_expired) begin
                            // A forced result is reported as an in-set pixel.
                            data_reg   <= max_iter_reg;
                            in_set_reg <= 1'b1;
                            if (wdog_count_reg != 8'hFF) wdog_count_reg <= wdog_count_reg + 8'd1;
                        end else begin
                            wdog_reg <= wdog_reg + 1'b1;
                        end
                    end
                end
                ADVANCE: begin
                    if (!abort) begin
                        addr_reg <= addr_reg + 1'b1;
                        if (x_reg == X_LAST) begin
                            x_reg <= '0;
                            y_reg <= y_reg + 10'd1;
                        end else begin
                            x_reg <= x_reg + 10'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign eng_pixel_x     = x_reg;
    assign eng_pixel_y     = y_reg;
    assign eng_pixel_valid = (state_reg == WAIT);
    assign eng_center_x    = center_x_reg;
    assign eng_center_y    = center_y_reg;
    assign eng_zoom        = zoom_reg;
    assign eng_max_iter    = max_iter_reg;
    assign eng_enable      = (state_reg != IDLE);
    assign busy            = (state_reg != IDLE);
    assign wr_valid        = (state_reg == WRITE);
    assign wr_addr         = addr_reg;
    assign wr_data         = data_reg;
    assign wr_in_set       = in_set_reg;
    assign frame_done      = frame_done_reg;
    assign wdog_count      = wdog_count_reg;

endmodule

// File: tb/tb_mandelbrot_frame_scheduler.sv
// Directed-plus-random bench: a small engine model answers with x+y after 3 cycles and a
// frame-level reference (expected address/data/in_set per pixel) checks every write.
module tb_mandelbrot_frame_scheduler;

    localparam int H  = 4;
    localparam int V  = 3;
    localparam int AW = 4;
    localparam int WD = 15;
    localparam int NPIX = H * V;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic [15:0]   cfg_center_x = '0;
    logic [15:0]   cfg_center_y = '0;
    logic [7:0]    cfg_zoom = '0;
    logic [5:0]    cfg_max_iter = '0;
    logic [9:0]    eng_pixel_x, eng_pixel_y;
    logic          eng_pixel_valid;
    logic [15:0]   eng_center_x, eng_center_y;
    logic [7:0]    eng_zoom;
    logic [5:0]    eng_max_iter;
    logic          eng_enable;
    logic [5:0]    eng_iteration_count = '0;
    logic          eng_result_valid = 1'b0;
    logic          eng_busy = 1'b0;
    logic          wr_valid;
    logic          wr_ready = 1'b0;
    logic [AW-1:0] wr_addr;
    logic [5:0]    wr_data;
    logic          wr_in_set;
    logic          busy;
    logic          frame_done;
    logic [7:0]    wdog_count;

    always #5 clk = ~clk;

    mandelbrot_frame_scheduler #(
        .H_RES(H), .V_RES(V), .ADDR_WIDTH(AW), .WDOG_CYCLES(WD)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .cfg_center_x(cfg_center_x), .cfg_center_y(cfg_center_y),
        .cfg_zoom(cfg_zoom), .cfg_max_iter(cfg_max_iter),
        .eng_pixel_x(eng_pixel_x), .eng_pixel_y(eng_pixel_y),
        .eng_pixel_valid(eng_pixel_valid),
        .eng_center_x(eng_center_x), .eng_center_y(eng_center_y),
        .eng_zoom(eng_zoom), .eng_max_iter(eng_max_iter), .eng_enable(eng_enable),
        .eng_iteration_count(eng_iteration_count), .eng_result_valid(eng_result_valid),
        .eng_busy(eng_busy),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_in_set(wr_in_set), .busy(busy), .frame_done(frame_done), .wdog_count(wdog_count)
    );

    // Engine model: accepts an idle request, answers x+y three cycles later.
    logic       drop_en = 1'b0;
    logic [9:0] drop_x = '0, drop_y = '0;
    int         eng_cnt = 0;
    logic [5:0] eng_res = '0;

    always @(posedge clk) begin
        if (!rst_n) begin
            eng_busy         <= 1'b0;
            eng_result_valid <= 1'b0;
            eng_cnt          <= 0;
        end else begin
            eng_result_valid <= 1'b0;
            if (eng_busy) begin
                if (eng_cnt == 1) begin
                    eng_busy            <= 1'b0;
                    eng_result_valid    <= 1'b1;
                    eng_iteration_count <= eng_res;
                end else begin
                    eng_cnt <= eng_cnt - 1;
                end
            end else if (!eng_result_valid && eng_pixel_valid &&
                         !(drop_en && eng_pixel_x == drop_x && eng_pixel_y == drop_y)) begin
                eng_busy <= 1'b1;
                eng_cnt  <= 3;
                eng_res  <= 6'(eng_pixel_x + eng_pixel_y);
            end
        end
    end

    int errors = 0;
    int checks = 0;

    logic [15:0] exp_cx, exp_cy;
    logic [7:0]  exp_zoom;
    logic [5:0]  exp_max;

    int wa[$];
    int wdat[$];
    int ws[$];
    int fd_count;
    int fd_at;
    int stall_left;
    int stall_err;
    int ovl_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_pixel_valid"}, 32'(eng_pixel_valid), 0);
        check({tag, "_pixel_xy"},    32'({eng_pixel_x, eng_pixel_y}), 0);
        check({tag, "_center"},      32'({eng_center_x, eng_center_y}), 0);
        check({tag, "_zoom_iter"},   32'({eng_zoom, eng_max_iter}), 0);
        check({tag, "_enable_busy"}, 32'({eng_enable, busy}), 0);
        check({tag, "_wr"},          32'({wr_valid, wr_addr, wr_data, wr_in_set}), 0);
        check({tag, "_frame_done"},  32'(frame_done), 0);
        check({tag, "_wdog_count"},  32'(wdog_count), 0);
    endtask

    task automatic set_cfg(input logic [5:0] mi);
        cfg_center_x = 16'($urandom);
        cfg_center_y = 16'($urandom);
        cfg_zoom     = 8'($urandom);
        cfg_max_iter = mi;
        exp_cx = cfg_center_x;
        exp_cy = cfg_center_y;
        exp_zoom = cfg_zoom;
        exp_max = mi;
    endtask

    // mode 0: ready always; 1: 5-cycle stall on stall_addr; 2: random ready
    task automatic run_frame(input int mode, input int stall_addr, input int abort_addr,
                             input int change_at, input logic [5:0] new_max);
        int n;
        logic prev_pv, prev_hold;
        logic [AW-1:0] h_addr;
        logic [5:0] h_data;
        logic h_set;
        wa.delete(); wdat.delete(); ws.delete();
        fd_count = 0; fd_at = -1; stall_left = 5; stall_err = 0; ovl_err = 0;
        prev_pv = 1'b0; prev_hold = 1'b0; n = 0;
        h_addr = '0; h_data = '0; h_set = 1'b0;
        @(negedge clk); start = 1'b1; wr_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", 32'(busy), 1);
        // Changes after start must not reach the engine this frame.
        cfg_center_x = 16'($urandom);
        cfg_zoom     = 8'($urandom);
        while (busy && n < 3000) begin
            if (mode == 1 && wr_valid && int'(wr_addr) == stall_addr && stall_left > 0) begin
                wr_ready = 1'b0;
                stall_left--;
            end else if (mode == 2) begin
                wr_ready = ($urandom_range(0, 2) != 0);
            end else begin
                wr_ready = 1'b1;
            end
            if (change_at >= 0 && wa.size() == change_at) cfg_max_iter = new_max;
            if (eng_pixel_valid && !prev_pv) begin
                check("pixel_x", 32'(eng_pixel_x), 32'(wa.size() % H));
                check("pixel_y", 32'(eng_pixel_y), 32'(wa.size() / H));
                check("eng_max_iter", 32'(eng_max_iter), 32'(exp_max));
                check("eng_center", 32'({eng_center_x, eng_center_y}), {exp_cx, exp_cy});
                check("eng_zoom", 32'(eng_zoom), 32'(exp_zoom));
            end
            if (eng_pixel_valid && wr_valid) ovl_err++;
            if (prev_hold && wr_valid && {wr_addr, wr_data, wr_in_set} != {h_addr, h_data, h_set})
                stall_err++;
            if (abort_addr >= 0 && wr_valid && int'(wr_addr) == abort_addr) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check("abort_busy", 32'(busy), 0);
                check("abort_wr_pv", 32'({wr_valid, eng_pixel_valid}), 0);
                break;
            end
            if (wr_valid && wr_ready) begin
                wa.push_back(int'(wr_addr));
                wdat.push_back(int'(wr_data));
                ws.push_back(int'(wr_in_set));
            end
            prev_hold = wr_valid && !wr_ready;
            h_addr = wr_addr; h_data = wr_data; h_set = wr_in_set;
            prev_pv = eng_pixel_valid;
            @(negedge clk);
            n++;
            if (frame_done) begin
                fd_count++;
                fd_at = wa.size();
            end
        end
        check("frame_timeout", 32'(n < 3000), 1);
        repeat (5) begin
            @(negedge clk);
            if (frame_done) fd_count++;
        end
        check("stall_stable", 32'(stall_err), 0);
        check("no_issue_during_write", 32'(ovl_err), 0);
    endtask

    task automatic verify_frame(input int drop_idx, input int exp_wdog);
        check("write_count", 32'(wa.size()), NPIX);
        for (int i = 0; i < wa.size() && i < NPIX; i++) begin
            int d;
            d = (i == drop_idx) ? int'(exp_max) : (i % H) + (i / H);
            check($sformatf("wr_addr[%0d]", i), 32'(wa[i]), 32'(i));
            check($sformatf("wr_data[%0d]", i), 32'(wdat[i]), 32'(d));
            check($sformatf("wr_in_set[%0d]", i), 32'(ws[i]), 32'(d >= int'(exp_max)));
        end
        check("frame_done_count", 32'(fd_count), 1);
        check("frame_done_after_last", 32'(fd_at), NPIX);
        check("wdog_count", 32'(wdog_count), 32'(exp_wdog));
    endtask

    initial begin
        int n;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;

        // Plain frame with random view and iteration limit.
        set_cfg(6'($urandom_range(1, 63)));
        run_frame(0, -1, -1, -1, 6'd0);
        verify_frame(-1, 0);
        $display("frame A: writes=%0d max_iter=%0d", wa.size(), exp_max);

        // Stalled write at addr 5 and a mid-frame iteration-limit change.
        set_cfg(6'd20);
        run_frame(1, 5, -1, 6, 6'd5);
        verify_frame(-1, 0);
        check("stall_applied", 32'(stall_left), 0);
        $display("frame B: writes=%0d stall_left=%0d", wa.size(), stall_left);

        // Engine never answers (2,1); random write back-pressure.
        set_cfg(6'($urandom_range(6, 63)));
        drop_en = 1'b1; drop_x = 10'd2; drop_y = 10'd1;
        run_frame(2, -1, -1, -1, 6'd0);
        drop_en = 1'b0;
        verify_frame(6, 1);
        $display("frame C: writes=%0d wdog=%0d", wa.size(), wdog_count);

        // Abort at addr 7, then a fresh frame restarts at addr 0.
        set_cfg(6'($urandom_range(1, 63)));
        run_frame(0, -1, 7, -1, 6'd0);
        check("abort_writes", 32'(wa.size()), 7);
        check("abort_no_frame_done", 32'(fd_count), 0);
        $display("frame D: aborted after %0d writes", wa.size());
        set_cfg(6'($urandom_range(1, 63)));
        run_frame(2, -1, -1, -1, 6'd0);
        verify_frame(-1, 0);
        $display("frame E: writes=%0d", wa.size());

        // Reset during WAIT clears everything; start held in reset is ignored.
        set_cfg(6'($urandom_range(1, 63)));
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!eng_pixel_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reached_wait", 32'(eng_pixel_valid), 1);
        rst_n = 1'b0; start = 1'b1;
        @(negedge clk);
        check_outputs_zero("mid_reset");
        rst_n = 1'b1; start = 1'b0;
        @(negedge clk);
        check("busy_after_reset", 32'(busy), 0);
        $display("reset in WAIT: busy=%0d", busy);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
